conv_out_tile_scheduler: RTL and testbench

Layer-level sequencer for the conv output-drain path. Walks one layer's output volume (OX × OY × OF) in tiles of TOX × TOY × TOF, presents each tile's 1-based start coordinates and clipped extents to the FIFO-drain controller, and fires its one-cycle start pulse. It starts a tile only when the compute array reports the tile's row FIFOs are filled. It then waits for the drain controller's tile-end pulse and releases the tile back to compute. It sits between the conv core/FIFO bank and the FIFO-drain controller.

---
 rtl/conv_sched_pkg.sv | 37 +++
 rtl/conv_tile_axis_counter.sv | 56 +++++
 rtl/conv_out_tile_scheduler.sv | 172 +++++++++++++++++
 tb/tb_conv_out_tile_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// ============================================================================
// Module  : conv_sched_pkg
// Brief   : Shared types and constants for the conv output tile scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package conv_sched_pkg;

    localparam int C_CH_MODE0 = 16;
    localparam int C_CH_MODE1 = 32;

    typedef logic [15:0] coord_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_READY = 3'd1,
        S_START      = 3'd2,
        S_BUSY       = 3'd3,
        S_ADVANCE    = 3'd4
    } sched_state_t;

    // Largest legal tile OF: every systolic row drains one FIFO row of channels.
    function automatic logic [16:0] max_pof(
        input logic mode,
        input int   sa_rows,
        input int   ch_mode0,
        input int   ch_mode1
    );
        int v;
        v = sa_rows * (mode ? ch_mode1 : ch_mode0);
        return 17'(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_tile_axis_counter.sv
// ============================================================================
// Module  : conv_tile_axis_counter
// Brief   : One tiling axis: 1-based tile start, clipped extent, wrap flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_tile_axis_counter
    import conv_sched_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  coord_t layer_dim,
    input  coord_t tile_size,
    input  logic   load,
    input  logic   step,
    input  logic   hold,
    output coord_t start,
    output coord_t extent,
    output logic   wrap
);

    coord_t      r_start;
    coord_t      r_extent;
    logic [16:0] w_sum;
    logic        w_wrap_cond;
    coord_t      w_next;
    logic [16:0] w_room;
    coord_t      w_ext;

    always_comb begin
        w_sum       = {1'b0, r_start} + {1'b0, tile_size};
        w_wrap_cond = w_sum > {1'b0, layer_dim};
        wrap        = step & w_wrap_cond;
        w_next      = (load || w_wrap_cond) ? 16'd1 : w_sum[15:0];
        w_room      = {1'b0, layer_dim} - {1'b0, w_next} + 17'd1;
        w_ext       = ({1'b0, tile_size} < w_room) ? tile_size : w_room[15:0];
    end

    // hold freezes the axis on the layer's final advance so the last tile stays visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start  <= '0;
            r_extent <= '0;
        end else if (load || (step && !hold)) begin
            r_start  <= w_next;
            r_extent <= w_ext;
        end
    end

    assign start  = r_start;
    assign extent = r_extent;

endmodule

`default_nettype wire

// File: rtl/conv_out_tile_scheduler.sv
// ============================================================================
// Module  : conv_out_tile_scheduler
// Brief   : Walks a layer's output volume tile by tile for the FIFO drain path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_out_tile_scheduler
    import conv_sched_pkg::*;
#(
    parameter int SA_ROW_NUM    = 4,
    parameter int SA_COLUMN_NUM = 3,
    parameter int CH_MODE0      = C_CH_MODE0,
    parameter int CH_MODE1      = C_CH_MODE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        layer_start,
    input  logic        mode,
    input  logic [15:0] layer_ox,
    input  logic [15:0] layer_oy,
    input  logic [15:0] layer_of,
    input  logic [15:0] tile_ox,
    input  logic [15:0] tile_oy,
    input  logic [15:0] tile_of,
    input  logic        tile_ready,
    input  logic        tile_end,
    output logic [15:0] cur_ox_start,
    output logic [15:0] cur_oy_start,
    output logic [15:0] cur_of_start,
    output logic [15:0] cur_pox,
    output logic [15:0] cur_poy,
    output logic [15:0] cur_pof,
    output logic        conv_fifo_out_start,
    output logic        tile_consumed,
    output logic        busy,
    output logic        layer_done,
    output logic        cfg_error
);

    sched_state_t r_state;
    sched_state_t w_state_next;

    coord_t r_layer_ox, r_layer_oy, r_layer_of;
    coord_t r_tile_ox, r_tile_oy, r_tile_of;
    logic   r_cfg_error;
    logic   r_err_done;

    coord_t w_layer_ox, w_layer_oy, w_layer_of;
    coord_t w_tile_ox, w_tile_oy, w_tile_of;
    logic   w_idle, w_accept, w_cfg_bad, w_load, w_adv, w_last;
    logic   w_of_wrap, w_ox_wrap, w_oy_wrap;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle & layer_start;
    assign w_adv    = (r_state == S_ADVANCE);
    assign w_last   = w_oy_wrap;

    always_comb begin
        w_cfg_bad = (layer_ox == '0) || (layer_oy == '0) || (layer_of == '0) ||
                    (tile_ox == '0) || (tile_oy == '0) || (tile_of == '0) ||
                    ({1'b0, tile_oy} > 17'(SA_COLUMN_NUM)) ||
                    ({1'b0, tile_of} > max_pof(mode, SA_ROW_NUM, CH_MODE0, CH_MODE1));
        w_load = w_accept & ~w_cfg_bad;
    end

    // Counters see the live ports in IDLE so the first tile loads in the accept cycle.
    always_comb begin
        w_layer_ox = w_idle ? layer_ox : r_layer_ox;
        w_layer_oy = w_idle ? layer_oy : r_layer_oy;
        w_layer_of = w_idle ? layer_of : r_layer_of;
        w_tile_ox  = w_idle ? tile_ox  : r_tile_ox;
        w_tile_oy  = w_idle ? tile_oy  : r_tile_oy;
        w_tile_of  = w_idle ? tile_of  : r_tile_of;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_layer_ox  <= '0;
            r_layer_oy  <= '0;
            r_layer_of  <= '0;
            r_tile_ox   <= '0;
            r_tile_oy   <= '0;
            r_tile_of   <= '0;
            r_cfg_error <= 1'b0;
            r_err_done  <= 1'b0;
        end else begin
            r_err_done <= w_accept & w_cfg_bad;
            if (w_accept) begin
                r_layer_ox  <= layer_ox;
                r_layer_oy  <= layer_oy;
                r_layer_of  <= layer_of;
                r_tile_ox   <= tile_ox;
                r_tile_oy   <= tile_oy;
                r_tile_of   <= tile_of;
                r_cfg_error <= w_cfg_bad;
            end
        end
    end

    // OF is innermost, then OX, then OY.
    conv_tile_axis_counter u_of_axis (
        .clk       (clk),
        .reset     (reset),
        .layer_dim (w_layer_of),
        .tile_size (w_tile_of),
        .load      (w_load),
        .step      (w_adv),
        .hold      (w_last),
        .start     (cur_of_start),
        .extent    (cur_pof),
        .wrap      (w_of_wrap)
    );

    conv_tile_axis_counter u_ox_axis (
        .clk       (clk),
        .reset     (reset),
        .layer_dim (w_layer_ox),
        .tile_size (w_tile_ox),
        .load      (w_load),
        .step      (w_of_wrap),
        .hold      (w_last),
        .start     (cur_ox_start),
        .extent    (cur_pox),
        .wrap      (w_ox_wrap)
    );

    conv_tile_axis_counter u_oy_axis (
        .clk       (clk),
        .reset     (reset),
        .layer_dim (w_layer_oy),
        .tile_size (w_tile_oy),
        .load      (w_load),
        .step      (w_ox_wrap),
        .hold      (w_last),
        .start     (cur_oy_start),
        .extent    (cur_poy),
        .wrap      (w_oy_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:       if (w_load)     w_state_next = S_WAIT_READY;
            S_WAIT_READY: if (tile_ready) w_state_next = S_START;
            S_START:                      w_state_next = S_BUSY;
            S_BUSY:       if (tile_end)   w_state_next = S_ADVANCE;
            S_ADVANCE:    w_state_next = w_last ? S_IDLE : S_WAIT_READY;
            default:                      w_state_next = S_IDLE;
        endcase
    end

    // Pulses are masked while reset is held so none escape in the reset cycle.
    always_comb begin
        conv_fifo_out_start = ~reset & (r_state == S_START);
        tile_consumed       = ~reset & w_adv;
        layer_done          = ~reset & (r_err_done | (w_adv & w_last));
        busy                = ~reset & ~w_idle & ~(w_adv & w_last);
        cfg_error           = r_cfg_error;
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_out_tile_scheduler.sv
// ============================================================================
// Module  : tb_conv_out_tile_scheduler
// Brief   : Directed self-checking bench for conv_out_tile_scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_conv_out_tile_scheduler;

    logic        clk;
    logic        reset;
    logic        layer_start;
    logic        mode;
    logic [15:0] layer_ox, layer_oy, layer_of;
    logic [15:0] tile_ox, tile_oy, tile_of;
    logic        tile_ready;
    logic        tile_end;
    logic [15:0] cur_ox_start, cur_oy_start, cur_of_start;
    logic [15:0] cur_pox, cur_poy, cur_pof;
    logic        conv_fifo_out_start;
    logic        tile_consumed;
    logic        busy;
    logic        layer_done;
    logic        cfg_error;

    logic [95:0] cur_vec;
    logic [4:0]  flag_vec;
    int          n_pass;
    int          n_total;

    assign cur_vec  = {cur_ox_start, cur_oy_start, cur_of_start, cur_pox, cur_poy, cur_pof};
    assign flag_vec = {conv_fifo_out_start, tile_consumed, busy, layer_done, cfg_error};

    conv_out_tile_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .layer_start         (layer_start),
        .mode                (mode),
        .layer_ox            (layer_ox),
        .layer_oy            (layer_oy),
        .layer_of            (layer_of),
        .tile_ox             (tile_ox),
        .tile_oy             (tile_oy),
        .tile_of             (tile_of),
        .tile_ready          (tile_ready),
        .tile_end            (tile_end),
        .cur_ox_start        (cur_ox_start),
        .cur_oy_start        (cur_oy_start),
        .cur_of_start        (cur_of_start),
        .cur_pox             (cur_pox),
        .cur_poy             (cur_poy),
        .cur_pof             (cur_pof),
        .conv_fifo_out_start (conv_fifo_out_start),
        .tile_consumed       (tile_consumed),
        .busy                (busy),
        .layer_done          (layer_done),
        .cfg_error           (cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input logic m, input logic [15:0] lox, loy, lof, tox, toy, tof);
        mode = m;
        layer_ox = lox; layer_oy = loy; layer_of = lof;
        tile_ox = tox;  tile_oy = toy;  tile_of = tof;
        layer_start = 1'b1;
        tick;
        layer_start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; layer_start = 1'b0; tile_ready = 1'b0; tile_end = 1'b0;
        mode = 1'b0;
        layer_ox = '0; layer_oy = '0; layer_of = '0;
        tile_ox = '0;  tile_oy = '0;  tile_of = '0;
        tick; tick;
        reset = 1'b0;
        tick;
        n_total++;
        if (flag_vec !== 5'b0) $display("FAIL reset_flags: got %b, want 00000", flag_vec);
        else n_pass++;
        n_total++;
        if (cur_vec !== 96'b0) $display("FAIL reset_cur: got %h, want 0", cur_vec);
        else n_pass++;
    endtask

    task automatic test_two_tiles;
        logic [95:0] exp_t [2];
        int k;
        exp_t[0] = {16'd1, 16'd1, 16'd1, 16'd32, 16'd3, 16'd64};
        exp_t[1] = {16'd1, 16'd4, 16'd1, 16'd32, 16'd3, 16'd64};
        tile_ready = 1'b1;
        start_layer(1'b0, 16'd32, 16'd6, 16'd64, 16'd32, 16'd3, 16'd64);
        n_total++;
        if (busy !== 1'b1 || cur_vec !== exp_t[0])
            $display("FAIL two_first_cycle: busy=%b cur=%h, want busy=1 cur=%h", busy, cur_vec, exp_t[0]);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            k = 0;
            while (conv_fifo_out_start !== 1'b1 && k < 20) begin tick; k++; end
            n_total++;
            if (k >= 20) $display("FAIL two_start_timeout tile %0d: start=%b, want 1", i, conv_fifo_out_start);
            else n_pass++;
            n_total++;
            if (cur_vec !== exp_t[i]) $display("FAIL two_cur tile %0d: got %h, want %h", i, cur_vec, exp_t[i]);
            else n_pass++;
            tick;
            tile_end = 1'b1; tick; tile_end = 1'b0;
            n_total++;
            if ({tile_consumed, layer_done, busy} !== {1'b1, i == 1, i != 1})
                $display("FAIL two_advance tile %0d: consumed/done/busy=%b%b%b, want 1%b%b",
                         i, tile_consumed, layer_done, busy, i == 1, i != 1);
            else n_pass++;
        end
        tick;
        n_total++;
        if (cur_vec !== exp_t[1] || layer_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL two_hold_after_done: cur=%h done=%b busy=%b, want cur=%h done=0 busy=0",
                     cur_vec, layer_done, busy, exp_t[1]);
        else n_pass++;
    endtask

    task automatic test_four_tiles;
        logic [95:0] exp_t [4];
        int k;
        exp_t[0] = {16'd1, 16'd1, 16'd1,  16'd32, 16'd3, 16'd64};
        exp_t[1] = {16'd1, 16'd1, 16'd65, 16'd32, 16'd3, 16'd16};
        exp_t[2] = {16'd1, 16'd4, 16'd1,  16'd32, 16'd1, 16'd64};
        exp_t[3] = {16'd1, 16'd4, 16'd65, 16'd32, 16'd1, 16'd16};
        tile_ready = 1'b1;
        start_layer(1'b0, 16'd32, 16'd4, 16'd80, 16'd32, 16'd3, 16'd64);
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (conv_fifo_out_start !== 1'b1 && k < 20) begin tick; k++; end
            n_total++;
            if (k >= 20) $display("FAIL four_start_timeout tile %0d: start=%b, want 1", i, conv_fifo_out_start);
            else n_pass++;
            n_total++;
            if (cur_vec !== exp_t[i]) $display("FAIL four_cur tile %0d: got %h, want %h", i, cur_vec, exp_t[i]);
            else n_pass++;
            tick;
            tile_end = 1'b1; tick; tile_end = 1'b0;
            n_total++;
            if ({tile_consumed, layer_done} !== {1'b1, i == 3})
                $display("FAIL four_advance tile %0d: consumed/done=%b%b, want 1%b",
                         i, tile_consumed, layer_done, i == 3);
            else n_pass++;
        end
        tick;
    endtask

    task automatic test_ready_hold;
        int bad;
        bad = 0;
        tile_ready = 1'b0;
        start_layer(1'b0, 16'd32, 16'd3, 16'd64, 16'd32, 16'd3, 16'd64);
        for (int i = 0; i < 10; i++) begin
            tile_end = (i == 4);
            tick;
            tile_end = 1'b0;
            if (conv_fifo_out_start !== 1'b0 || tile_consumed !== 1'b0 || busy !== 1'b1) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL ready_hold_quiet: %0d bad cycles, want 0", bad);
        else n_pass++;
        tile_ready = 1'b1;
        tick;
        n_total++;
        if (conv_fifo_out_start !== 1'b1) $display("FAIL ready_rise_start: got %b, want 1", conv_fifo_out_start);
        else n_pass++;
        tick;
        n_total++;
        if (conv_fifo_out_start !== 1'b0) $display("FAIL ready_single_pulse: got %b, want 0", conv_fifo_out_start);
        else n_pass++;
        tile_end = 1'b1; tick; tile_end = 1'b0;
        n_total++;
        if ({tile_consumed, layer_done, busy} !== 3'b110)
            $display("FAIL ready_single_done: consumed/done/busy=%b%b%b, want 110", tile_consumed, layer_done, busy);
        else n_pass++;
        tick;
    endtask

    task automatic test_cfg_errors;
        int bad;
        int k;
        tile_ready = 1'b1;
        start_layer(1'b0, 16'd32, 16'd6, 16'd64, 16'd32, 16'd4, 16'd64);
        n_total++;
        if ({cfg_error, layer_done, busy, conv_fifo_out_start} !== 4'b1100)
            $display("FAIL cfg_oy_err: err/done/busy/start=%b%b%b%b, want 1100",
                     cfg_error, layer_done, busy, conv_fifo_out_start);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (conv_fifo_out_start !== 1'b0 || busy !== 1'b0 || layer_done !== 1'b0 || cfg_error !== 1'b1) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL cfg_oy_quiet: %0d bad cycles, want 0", bad);
        else n_pass++;

        start_layer(1'b1, 16'd32, 16'd3, 16'd100, 16'd32, 16'd3, 16'd100);
        n_total++;
        if (cfg_error !== 1'b0 || busy !== 1'b1 || cur_vec !== {16'd1, 16'd1, 16'd1, 16'd32, 16'd3, 16'd100})
            $display("FAIL cfg_of100_mode1: err=%b busy=%b cur=%h, want err=0 busy=1 cur=%h",
                     cfg_error, busy, cur_vec, {16'd1, 16'd1, 16'd1, 16'd32, 16'd3, 16'd100});
        else n_pass++;
        k = 0;
        while (conv_fifo_out_start !== 1'b1 && k < 20) begin tick; k++; end
        tick;
        tile_end = 1'b1; tick; tile_end = 1'b0;
        n_total++;
        if (layer_done !== 1'b1) $display("FAIL cfg_mode1_done: got %b, want 1", layer_done);
        else n_pass++;
        tick;

        start_layer(1'b0, 16'd32, 16'd3, 16'd100, 16'd32, 16'd3, 16'd100);
        n_total++;
        if ({cfg_error, layer_done, busy} !== 3'b110)
            $display("FAIL cfg_of100_mode0: err/done/busy=%b%b%b, want 110", cfg_error, layer_done, busy);
        else n_pass++;
        tick;
    endtask

    task automatic test_reset_busy;
        tile_ready = 1'b1;
        start_layer(1'b0, 16'd32, 16'd6, 16'd64, 16'd32, 16'd3, 16'd64);
        tick; tick;
        n_total++;
        if (busy !== 1'b1 || conv_fifo_out_start !== 1'b0)
            $display("FAIL rst_busy_pre: busy=%b start=%b, want 1 0", busy, conv_fifo_out_start);
        else n_pass++;
        reset = 1'b1;
        tick;
        n_total++;
        if (flag_vec !== 5'b0 || cur_vec !== 96'b0)
            $display("FAIL rst_busy_outputs: flags=%b cur=%h, want 0 0", flag_vec, cur_vec);
        else n_pass++;
        reset = 1'b0;
        tile_end = 1'b1; tick; tile_end = 1'b0;
        n_total++;
        if (flag_vec !== 5'b0) $display("FAIL rst_busy_after: flags=%b, want 00000", flag_vec);
        else n_pass++;
    endtask

    task automatic test_layer_start_busy;
        logic [95:0] exp_t [2];
        int k;
        exp_t[0] = {16'd1, 16'd1, 16'd1, 16'd32, 16'd3, 16'd64};
        exp_t[1] = {16'd1, 16'd4, 16'd1, 16'd32, 16'd3, 16'd64};
        tile_ready = 1'b1;
        start_layer(1'b0, 16'd32, 16'd6, 16'd64, 16'd32, 16'd3, 16'd64);
        for (int i = 0; i < 2; i++) begin
            k = 0;
            while (conv_fifo_out_start !== 1'b1 && k < 20) begin tick; k++; end
            n_total++;
            if (k >= 20 || cur_vec !== exp_t[i])
                $display("FAIL lsb_tile %0d: waited=%0d cur=%h, want cur=%h", i, k, cur_vec, exp_t[i]);
            else n_pass++;
            tick;
            if (i == 0) begin
                layer_ox = 16'd8; layer_of = 16'd16; tile_of = 16'd1; tile_oy = 16'd1;
                layer_start = 1'b1; tick; layer_start = 1'b0;
                n_total++;
                if (busy !== 1'b1 || conv_fifo_out_start !== 1'b0 || cur_vec !== exp_t[0])
                    $display("FAIL lsb_ignored: busy=%b start=%b cur=%h, want 1 0 %h",
                             busy, conv_fifo_out_start, cur_vec, exp_t[0]);
                else n_pass++;
            end
            tile_end = 1'b1; tick; tile_end = 1'b0;
            n_total++;
            if ({tile_consumed, layer_done} !== {1'b1, i == 1})
                $display("FAIL lsb_advance tile %0d: consumed/done=%b%b, want 1%b", i, tile_consumed, layer_done, i == 1);
            else n_pass++;
        end
        tick;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset;
        test_two_tiles;
        test_four_tiles;
        test_ready_hold;
        test_cfg_errors;
        test_reset_busy;
        test_layer_start_busy;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
